// File: rtl/dram_fifo_rd_ctrl.sv
//------------------------------------------------------------------------------
// Module  : dram_fifo_rd_ctrl
// Purpose : Read-side controller for a distributed-RAM FIFO. It fetches words
//           from a combinational-read SDPRAM and presents them as a
//           valid/ready stream. Define DRAM_FIFO_RD_SKID_EN for a two-entry
//           output stage; otherwise a single output register is used.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module dram_fifo_rd_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [ADDR_WIDTH:0]   wr_ptr,
  output logic [ADDR_WIDTH:0]   rd_ptr,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ADDR_WIDTH:0]   ram_level,
  output logic                  ovf_err
);

  localparam logic [ADDR_WIDTH:0] C_DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] C_PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

`ifdef DRAM_FIFO_RD_SKID_EN
  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_TWO = 2'd2} state_t;
`else
  typedef enum logic [0:0] {S_EMPTY = 1'b0, S_ONE = 1'b1} state_t;
`endif

  state_t                  r_state, w_state_nxt;
  logic [ADDR_WIDTH:0]     r_rd_ptr, w_rd_ptr_nxt;
  logic [DATA_WIDTH-1:0]   r_head, w_head_nxt;
  logic                    r_ovf;
  logic                    w_fetch;
  logic                    w_pop;
  logic                    w_ram_nonempty;
`ifdef DRAM_FIFO_RD_SKID_EN
  logic [DATA_WIDTH-1:0]   r_skid, w_skid_nxt;
`endif

  assign ram_level      = wr_ptr - r_rd_ptr;
  assign w_ram_nonempty = (ram_level != '0);
  assign rd_ptr         = r_rd_ptr;
  assign ram_rd_addr    = r_rd_ptr[ADDR_WIDTH-1:0];
  assign m_data         = r_head;
  assign m_valid        = (r_state != S_EMPTY);
  assign ovf_err        = r_ovf;
  assign w_pop          = m_valid && m_ready && !flush;

`ifdef DRAM_FIFO_RD_SKID_EN
  // Fetch is decided from registered state only, keeping m_ready off the address path.
  assign w_fetch = w_ram_nonempty && (r_state != S_TWO) && !flush;
`else
  assign w_fetch = w_ram_nonempty && (!m_valid || m_ready) && !flush;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_head_nxt   = r_head;
    w_rd_ptr_nxt = r_rd_ptr;
`ifdef DRAM_FIFO_RD_SKID_EN
    w_skid_nxt   = r_skid;
`endif
    if (flush) begin
      w_state_nxt  = S_EMPTY;
      w_rd_ptr_nxt = wr_ptr;
    end else begin
      if (w_fetch) begin
        w_rd_ptr_nxt = r_rd_ptr + C_PTR_ONE;
      end
      case (r_state)
        S_EMPTY: begin
          if (w_fetch) begin
            w_head_nxt  = ram_rd_data;
            w_state_nxt = S_ONE;
          end
        end
        S_ONE: begin
`ifdef DRAM_FIFO_RD_SKID_EN
          if (w_fetch && w_pop) begin
            w_head_nxt = ram_rd_data;
          end else if (w_fetch) begin
            w_skid_nxt  = ram_rd_data;
            w_state_nxt = S_TWO;
          end else if (w_pop) begin
            w_state_nxt = S_EMPTY;
          end
`else
          // In ONE a fetch is only enabled alongside a pop, so the head is replaced.
          if (w_fetch) begin
            w_head_nxt = ram_rd_data;
          end else if (w_pop) begin
            w_state_nxt = S_EMPTY;
          end
`endif
        end
`ifdef DRAM_FIFO_RD_SKID_EN
        S_TWO: begin
          if (w_pop) begin
            w_head_nxt  = r_skid;
            w_state_nxt = S_ONE;
          end
        end
`endif
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_EMPTY;
      r_rd_ptr <= '0;
      r_head   <= '0;
      r_ovf    <= 1'b0;
`ifdef DRAM_FIFO_RD_SKID_EN
      r_skid   <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_head   <= w_head_nxt;
      r_ovf    <= r_ovf | (ram_level > C_DEPTH);
`ifdef DRAM_FIFO_RD_SKID_EN
      r_skid   <= w_skid_nxt;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dram_fifo_rd_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_dram_fifo_rd_ctrl
// Purpose : Directed self-checking bench for dram_fifo_rd_ctrl (either build
//           selected by DRAM_FIFO_RD_SKID_EN).
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_dram_fifo_rd_ctrl;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam logic [AW:0] ONE = 5'd1;
`ifdef DRAM_FIFO_RD_SKID_EN
  localparam logic [AW:0] STALL_LEVEL = 5'd14;
`else
  localparam logic [AW:0] STALL_LEVEL = 5'd15;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          m_ready = 1'b0;
  logic [AW:0]   wr_ptr = '0;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   ram_level;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          ovf_err;
  logic [DW-1:0] mem [0:15];
  logic [AW:0]   tb_lvl;
  int            checks = 0;
  int            failures = 0;

  always #5 clk = ~clk;

  assign ram_rd_data = mem[ram_rd_addr];

  dram_fifo_rd_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .wr_ptr      (wr_ptr),
    .rd_ptr      (rd_ptr),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .ram_level   (ram_level),
    .ovf_err     (ovf_err)
  );

  task automatic wr_word(input logic [DW-1:0] d);
    mem[wr_ptr[AW-1:0]] = d;
    wr_ptr = wr_ptr + ONE;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; m_ready = 1'b0; wr_ptr = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_ptr = '0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || m_data !== 8'h00 || rd_ptr !== 5'd0 || ovf_err !== 1'b0 ||
        ram_level !== 5'd0 || ram_rd_addr !== 4'd0) begin
      failures++;
      $display("FAIL reset_state valid=%b data=%h rd_ptr=%0d ovf=%b level=%0d addr=%0d required 0", m_valid, m_data, rd_ptr, ovf_err, ram_level, ram_rd_addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [DW-1:0] exp_d [3];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
    do_reset();
    m_ready = 1'b1;
    wr_word(exp_d[0]);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b1 || m_data !== exp_d[i]) begin
        failures++;
        $display("FAIL basic_word%0d valid=%b data=%h required 1/%h", i, m_valid, m_data, exp_d[i]);
      end
      if (i < 2) wr_word(exp_d[i+1]);
    end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || rd_ptr !== 5'd3 || ram_level !== 5'd0) begin
      failures++;
      $display("FAIL basic_end valid=%b rd_ptr=%0d level=%0d required 0/3/0", m_valid, rd_ptr, ram_level);
    end
  endtask

  task automatic test_stall();
    int idx;
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wr_word(8'(i));
      @(negedge clk);
    end
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== 8'h00) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d valid=%b data=%h required 1/00", c, m_valid, m_data);
      end
      @(negedge clk);
    end
    checks++;
    if (ram_level !== STALL_LEVEL) begin
      failures++;
      $display("FAIL stall_level level=%0d required %0d", ram_level, STALL_LEVEL);
    end
    m_ready = 1'b1;
    idx = 0;
    for (int c = 0; c < 40 && idx < 16; c++) begin
      if (m_valid) begin
        checks++;
        if (m_data !== 8'(idx)) begin
          failures++;
          $display("FAIL stall_drain idx=%0d data=%h required %h", idx, m_data, 8'(idx));
        end
        idx++;
      end
      @(negedge clk);
    end
    checks++;
    if (idx != 16 || m_valid !== 1'b0 || ram_level !== 5'd0) begin
      failures++;
      $display("FAIL stall_count words=%0d valid=%b level=%0d required 16/0/0", idx, m_valid, ram_level);
    end
  endtask

  task automatic test_wrap();
    int   idx = 0;
    int   gaps = 0;
    logic seen = 1'b0;
    logic saw_wrap = 1'b0;
    logic [AW:0] prev_rp;
    prev_rp = rd_ptr;
    m_ready = 1'b1;
    for (int c = 0; c < 60 && idx < 40; c++) begin
      if (m_valid) begin
        checks++;
        if (m_data !== 8'(idx)) begin
          failures++;
          $display("FAIL wrap_data idx=%0d data=%h required %h", idx, m_data, 8'(idx));
        end
        idx++;
        seen = 1'b1;
      end else if (seen) begin
        gaps++;
      end
      if (c < 40) wr_word(8'(c));
      @(negedge clk);
      if (prev_rp == 5'd31 && rd_ptr == 5'd0) saw_wrap = 1'b1;
      prev_rp = rd_ptr;
    end
    checks++;
    if (idx != 40 || gaps != 0 || saw_wrap !== 1'b1) begin
      failures++;
      $display("FAIL wrap_stream words=%0d gaps=%0d wrapped=%b required 40/0/1", idx, gaps, saw_wrap);
    end
  endtask

  task automatic test_random();
    int   sent = 0;
    int   got = 0;
    logic stalled = 1'b0;
    logic [DW-1:0] held = '0;
    for (int c = 0; c < 3000 && got < 200; c++) begin
      if (stalled) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== held) begin
          failures++;
          $display("FAIL random_stall cyc=%0d valid=%b data=%h required 1/%h", c, m_valid, m_data, held);
        end
      end
      m_ready = 1'($urandom_range(0, 1));
      if (m_valid && m_ready) begin
        checks++;
        if (m_data !== 8'(got * 3 + 1)) begin
          failures++;
          $display("FAIL random_data word=%0d data=%h required %h", got, m_data, 8'(got * 3 + 1));
        end
        got++;
      end
      stalled = m_valid && !m_ready;
      held = m_data;
      tb_lvl = wr_ptr - rd_ptr;
      if (sent < 200 && tb_lvl < 5'd16 && $urandom_range(0, 3) != 0) begin
        wr_word(8'(sent * 3 + 1));
        sent++;
      end
      @(negedge clk);
    end
    checks++;
    if (got != 200) begin
      failures++;
      $display("FAIL random_count words=%0d required 200", got);
    end
  endtask

  task automatic test_ovf();
    m_ready = 1'b0;
    checks++;
    if (ovf_err !== 1'b0) begin
      failures++;
      $display("FAIL ovf_pre ovf=%b required 0", ovf_err);
    end
    wr_ptr = rd_ptr + 5'd17;
    @(negedge clk);
    checks++;
    if (ovf_err !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set ovf=%b required 1", ovf_err);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (ovf_err !== 1'b1 || m_valid !== 1'b0 || rd_ptr !== wr_ptr || ram_level !== 5'd0) begin
      failures++;
      $display("FAIL ovf_flush ovf=%b valid=%b rd_ptr=%0d level=%0d required 1/0/%0d/0", ovf_err, m_valid, rd_ptr, ram_level, wr_ptr);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ovf_err !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sticky ovf=%b required 1", ovf_err);
    end
    rst = 1'b1; wr_ptr = '0;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (ovf_err !== 1'b0 || rd_ptr !== 5'd0) begin
      failures++;
      $display("FAIL ovf_clear ovf=%b rd_ptr=%0d required 0/0", ovf_err, rd_ptr);
    end
  endtask

  task automatic test_flush();
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_word(8'hC0 + 8'(i));
      @(negedge clk);
    end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'hC0) begin
      failures++;
      $display("FAIL flush_pre valid=%b data=%h required 1/c0", m_valid, m_data);
    end
    m_ready = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || rd_ptr !== 5'd5 || ram_level !== 5'd0) begin
      failures++;
      $display("FAIL flush_state valid=%b rd_ptr=%0d level=%0d required 0/5/0", m_valid, rd_ptr, ram_level);
    end
    wr_word(8'hA5);
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'hA5) begin
      failures++;
      $display("FAIL flush_after valid=%b data=%h required 1/a5", m_valid, m_data);
    end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || rd_ptr !== 5'd6) begin
      failures++;
      $display("FAIL flush_drain valid=%b rd_ptr=%0d required 0/6", m_valid, rd_ptr);
    end
  endtask

  task automatic test_flush_rst();
    m_ready = 1'b0;
    rst = 1'b1; flush = 1'b1; wr_ptr = 5'd3;
    @(negedge clk);
    rst = 1'b0; flush = 1'b0;
    checks++;
    if (rd_ptr !== 5'd0 || ram_level !== 5'd3 || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_rst rd_ptr=%0d level=%0d valid=%b required 0/3/0", rd_ptr, ram_level, m_valid);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_random();
    test_ovf();
    test_flush();
    test_flush_rst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule

`default_nettype wire
